// File: rtl/alu_result_queue.sv
// alu_result_queue: small valid/ready FIFO holding ALU results and flags, with a
// branch-condition decode on the head entry.
// Optional feature macro: ALU_STICKY_FLAGS_EN (accumulates Carry/Overflow seen on pushes).
module alu_result_queue #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           C,
   input  logic                       Sign,
   input  logic                       Zero,
   input  logic                       Parity,
   input  logic                       Carry,
   input  logic                       Overflow,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_res,
   output logic [4:0]                 out_flags,
   input  logic [3:0]                 cond_sel,
   output logic                       cond_true,
   output logic [$clog2(DEPTH):0]     level,
   output logic [1:0]                 sticky_cv,
   input  logic                       sticky_clr
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [WIDTH-1:0] res_mem_q   [DEPTH];
   logic [4:0]       flags_mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             push, pop;
   logic [4:0]       head_flags;
   logic             f_s, f_z, f_p, f_c, f_v;
   logic             cond_raw;

   // Handshake decode; in_ready looks only at registered level (no pass-through when full).
   always_comb begin
      in_ready  = (level_q != LW'(DEPTH));
      out_valid = (level_q != '0);
      push      = in_valid & in_ready;
      pop       = out_valid & out_ready;
   end

   // Next-state for pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Entry storage; left unreset because outputs are masked by out_valid.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         res_mem_q[wr_ptr_q]   <= C;
         flags_mem_q[wr_ptr_q] <= {Sign, Zero, Parity, Carry, Overflow};
      end
   end

   // Head outputs and branch-condition decode, all masked when empty.
   always_comb begin
      head_flags = flags_mem_q[rd_ptr_q];
      {f_s, f_z, f_p, f_c, f_v} = head_flags;
      cond_raw = 1'b0;
      case (cond_sel)
         4'd0:    cond_raw = 1'b1;
         4'd1:    cond_raw = f_z;
         4'd2:    cond_raw = !f_z;
         4'd3:    cond_raw = f_c;
         4'd4:    cond_raw = !f_c;
         4'd5:    cond_raw = f_s;
         4'd6:    cond_raw = f_v;
         4'd7:    cond_raw = f_s ^ f_v;
         4'd8:    cond_raw = !(f_s ^ f_v) && !f_z;
         4'd9:    cond_raw = !f_p;
         default: cond_raw = 1'b0;
      endcase
      out_res   = out_valid ? res_mem_q[rd_ptr_q] : '0;
      out_flags = out_valid ? head_flags : '0;
      cond_true = out_valid & cond_raw;
      level     = level_q;
   end

`ifdef ALU_STICKY_FLAGS_EN
   logic [1:0] sticky_q, sticky_d;

   // Clear first, then OR in the pushed flags so a same-cycle set wins.
   always_comb begin
      sticky_d = sticky_clr ? 2'b00 : sticky_q;
      if (push) sticky_d = sticky_d | {Carry, Overflow};
   end

   // Sticky flag register.
   always_ff @(posedge clk) begin
      if (rst) sticky_q <= 2'b00;
      else     sticky_q <= sticky_d;
   end

   assign sticky_cv = sticky_q;
`else
   logic unused_sticky_clr;
   assign unused_sticky_clr = sticky_clr;
   assign sticky_cv         = 2'b00;
`endif

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed self-checking bench for alu_result_queue with a result scoreboard.
module tb_alu_result_queue;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned DEPTH = 2;
`ifdef ALU_STICKY_FLAGS_EN
   localparam bit StickyEn = 1'b1;
`else
   localparam bit StickyEn = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid, in_ready;
   logic [WIDTH-1:0] c_in;
   logic             sign_in, zero_in, parity_in, carry_in, ovf_in;
   logic             out_valid, out_ready;
   logic [WIDTH-1:0] out_res;
   logic [4:0]       out_flags;
   logic [3:0]       cond_sel;
   logic             cond_true;
   logic [1:0]       level;
   logic [1:0]       sticky_cv;
   logic             sticky_clr;

   int total = 0;
   int bad   = 0;
   logic [20:0] sb[$];

   alu_result_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .C(c_in),
      .Sign(sign_in), .Zero(zero_in), .Parity(parity_in), .Carry(carry_in),
      .Overflow(ovf_in), .out_valid(out_valid), .out_ready(out_ready),
      .out_res(out_res), .out_flags(out_flags), .cond_sel(cond_sel),
      .cond_true(cond_true), .level(level), .sticky_cv(sticky_cv),
      .sticky_clr(sticky_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [15:0] d, input logic [4:0] f);
      in_valid = v;
      c_in     = d;
      {sign_in, zero_in, parity_in, carry_in, ovf_in} = f;
   endtask

   // One clock: record pushes, compare pops against the scoreboard, then advance.
   task automatic tick();
      logic [20:0] exp_e;
      #1;
      if (in_valid && in_ready) sb.push_back({c_in, sign_in, zero_in, parity_in, carry_in, ovf_in});
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("pop_with_empty_model", 32'(out_valid), 32'd0);
         end else begin
            exp_e = sb.pop_front();
            check("pop_res", 32'(out_res), 32'(exp_e[20:5]));
            check("pop_flags", 32'(out_flags), 32'(exp_e[4:0]));
         end
      end
      @(posedge clk);
      #1;
      check("level_vs_model", 32'(level), 32'(sb.size()));
   endtask

   initial begin
      rst = 1'b1; out_ready = 1'b0; cond_sel = 4'd0; sticky_clr = 1'b0;
      drive(1'b0, 16'h0, 5'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      // Reset state.
      check("rst_level", 32'(level), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_res", 32'(out_res), 32'd0);
      check("rst_out_flags", 32'(out_flags), 32'd0);
      check("rst_cond_true", 32'(cond_true), 32'd0);
      check("rst_sticky", 32'(sticky_cv), 32'd0);

      // Zero result, cond_sel=1.
      cond_sel = 4'd1;
      drive(1'b1, 16'h0000, 5'b01100);
      tick();
      drive(1'b0, 16'h0, 5'b0);
      #1;
      check("z_out_valid", 32'(out_valid), 32'd1);
      check("z_out_res", 32'(out_res), 32'h0000);
      check("z_out_flags", 32'(out_flags), 32'b01100);
      check("z_cond_true", 32'(cond_true), 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("z_drained_valid", 32'(out_valid), 32'd0);

      // Pop while empty is ignored.
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("empty_pop_level", 32'(level), 32'd0);

      // Fill to full, then hold a third push.
      drive(1'b1, 16'h1234, 5'b00000);
      tick();
      drive(1'b1, 16'h8000, 5'b10000);
      tick();
      check("full_level", 32'(level), 32'd2);
      check("full_in_ready", 32'(in_ready), 32'd0);
      drive(1'b1, 16'h00FF, 5'b00100);
      tick();
      check("held_level", 32'(level), 32'd2);
      // Full with push and pop: pop only.
      out_ready = 1'b1;
      tick();
      check("full_pushpop_level", 32'(level), 32'd1);
      check("after_pop_in_ready", 32'(in_ready), 32'd1);
      // Held input accepted alongside a pop at level 1.
      tick();
      check("mid_pushpop_level", 32'(level), 32'd1);
      drive(1'b0, 16'h0, 5'b0);
      tick();
      out_ready = 1'b0;
      check("drained_level", 32'(level), 32'd0);

      // Signed conditions on a negative head.
      drive(1'b1, 16'h8000, 5'b10000);
      tick();
      drive(1'b0, 16'h0, 5'b0);
      cond_sel = 4'd7;  #1 check("cond7_slt", 32'(cond_true), 32'd1);
      cond_sel = 4'd8;  #1 check("cond8_sgt", 32'(cond_true), 32'd0);
      cond_sel = 4'd12; #1 check("cond12", 32'(cond_true), 32'd0);
      cond_sel = 4'd1;  #1 check("cond1_z", 32'(cond_true), 32'd0);
      cond_sel = 4'd9;  #1 check("cond9_oddp", 32'(cond_true), 32'd1);
      cond_sel = 4'd5;  #1 check("cond5_s", 32'(cond_true), 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Positive non-zero head: signed gt true, carry conditions.
      drive(1'b1, 16'h0003, 5'b00110);
      tick();
      drive(1'b0, 16'h0, 5'b0);
      cond_sel = 4'd8; #1 check("cond8_sgt_pos", 32'(cond_true), 32'd1);
      cond_sel = 4'd3; #1 check("cond3_c", 32'(cond_true), 32'd1);
      cond_sel = 4'd4; #1 check("cond4_nc", 32'(cond_true), 32'd0);
      cond_sel = 4'd2; #1 check("cond2_nz", 32'(cond_true), 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("sticky_after_carry_pop", 32'(sticky_cv), StickyEn ? 32'b10 : 32'b00);

      // Sticky flags: clear with a same-cycle overflow push.
      drive(1'b1, 16'h7FFF, 5'b00001);
      sticky_clr = 1'b1;
      tick();
      sticky_clr = 1'b0;
      drive(1'b0, 16'h0, 5'b0);
      check("sticky_clr_set", 32'(sticky_cv), StickyEn ? 32'b01 : 32'b00);
      sticky_clr = 1'b1;
      tick();
      sticky_clr = 1'b0;
      check("sticky_clr_only", 32'(sticky_cv), 32'b00);

      // Mid-stream reset with a push in the reset cycle.
      drive(1'b1, 16'hABCD, 5'b10011);
      tick();
      check("pre_rst_level", 32'(level), 32'd2);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      drive(1'b0, 16'h0, 5'b0);
      sb.delete();
      #1;
      check("mrst_level", 32'(level), 32'd0);
      check("mrst_out_valid", 32'(out_valid), 32'd0);
      check("mrst_in_ready", 32'(in_ready), 32'd1);
      check("mrst_sticky", 32'(sticky_cv), 32'd0);
      check("mrst_out_flags", 32'(out_flags), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time bound so the bench always ends.
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
